// File: rtl/ysyx_041461_hazard_ctrl_if.sv
// Purpose: status/control bundle between the pipeline and the hazard controller.
// Latency: none; wires only.
// Backpressure: none; enables and bubbles travel as plain levels.
//
// Port summary:
//   status from the pipeline -> ID/EXE register fields, mul/div pulses, MEM handshake
//   control to the pipeline  -> *reg_enable, *reg_valid_fromCD, mem_timeout, perf counters
interface ysyx_041461_hazard_ctrl_if #(
   parameter int CNT_W = 32
) ();
   logic             ID_valid;
   logic [4:0]       ID_rs1;
   logic [4:0]       ID_rs2;
   logic             ID_rs1_used;
   logic             ID_rs2_used;
   logic             EXE_valid;
   logic [4:0]       EXE_rd;
   logic             EXE_is_load;
   logic             EXE_redirect;
   logic             EXE_md_start;
   logic             EXE_md_done;
   logic             MEM_req_valid;
   logic             MEM_ready;

   logic             IFreg_enable;
   logic             IDreg_enable;
   logic             EXEreg_enable;
   logic             MEMreg_enable;
   logic             IDreg_valid_fromCD;
   logic             EXEreg_valid_fromCD;
   logic             MEMreg_valid_fromCD;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Pipeline side: reports stage status, consumes enables and bubbles.
   modport master (
      output ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
      output EXE_valid, EXE_rd, EXE_is_load, EXE_redirect, EXE_md_start, EXE_md_done,
      output MEM_req_valid, MEM_ready,
      input  IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable,
      input  IDreg_valid_fromCD, EXEreg_valid_fromCD, MEMreg_valid_fromCD,
      input  mem_timeout, stall_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  ID_valid, ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
      input  EXE_valid, EXE_rd, EXE_is_load, EXE_redirect, EXE_md_start, EXE_md_done,
      input  MEM_req_valid, MEM_ready,
      output IFreg_enable, IDreg_enable, EXEreg_enable, MEMreg_enable,
      output IDreg_valid_fromCD, EXEreg_valid_fromCD, MEMreg_valid_fromCD,
      output mem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/ysyx_041461_hazard_ctrl.sv
// Purpose: pipeline hazard/stall controller (load-use, redirect, mul/div hold, memory wait, watchdog).
// Latency: enables/bubbles are combinational, same cycle as the causing condition.
// Backpressure: freezes IF/ID/EXE (and MEM on memory wait) by dropping the register enables.
//
// Port summary:
//   clk, rst : single clock, synchronous active-high reset
//   hc       : slave side of ysyx_041461_hazard_ctrl_if (stage status in, enables/bubbles/counters out)
module ysyx_041461_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 1024,
   parameter int CNT_W       = 32
) (
   input logic                      clk,
   input logic                      rst,
   ysyx_041461_hazard_ctrl_if.slave hc
);

   localparam int                WCNT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MD_BUSY  = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_ERROR    = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WCNT_W-1:0] r_wcnt;
   logic [WCNT_W-1:0] w_wcnt_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic w_mem_stall;
   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_hazard;
   logic w_md_hold;
   logic w_flush;
   logic w_if_en;
   logic w_id_en;
   logic w_exe_en;
   logic w_mem_en;
   logic w_id_vld;
   logic w_exe_vld;
   logic w_mem_vld;

   // ---------------------------------------------------------------
   // Condition decode
   // ---------------------------------------------------------------
   always_comb begin
      w_mem_stall = hc.MEM_req_valid & ~hc.MEM_ready;
      w_rs1_hit   = hc.ID_rs1_used & (hc.ID_rs1 == hc.EXE_rd);
      w_rs2_hit   = hc.ID_rs2_used & (hc.ID_rs2 == hc.EXE_rd);
      w_hazard    = hc.ID_valid & hc.EXE_valid & hc.EXE_is_load & (hc.EXE_rd != 5'd0)
                    & (w_rs1_hit | w_rs2_hit);
      // A start seen during a memory stall is not accepted, so it must not open a hold.
      // A start that completes in the same cycle needs no hold either.
      w_md_hold   = ((r_state == ST_MD_BUSY)
                     | ((r_state == ST_RUN) & hc.EXE_valid & hc.EXE_md_start & ~w_mem_stall))
                    & ~hc.EXE_md_done;
   end

   // ---------------------------------------------------------------
   // State / watchdog next-state
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      case (r_state)
         ST_RUN: begin
            if (w_mem_stall) begin
               w_state_nxt = ST_MEM_WAIT;
               w_wcnt_nxt  = WCNT_W'(1);
            end else if (w_md_hold) begin
               w_state_nxt = ST_MD_BUSY;
            end
         end
         ST_MEM_WAIT: begin
            // Completion on the last allowed cycle still counts as success.
            if (hc.MEM_ready) begin
               w_state_nxt = ST_RUN;
               w_wcnt_nxt  = '0;
            end else if (r_wcnt == WCNT_LAST) begin
               w_state_nxt = ST_ERROR;
            end else begin
               w_wcnt_nxt  = r_wcnt + WCNT_W'(1);
            end
         end
         ST_MD_BUSY: begin
            // A memory stall of an older op only freezes MEM; the hold continues.
            if (hc.EXE_md_done) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_ERROR: begin
            w_state_nxt = ST_ERROR;
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Enable / bubble generation, first matching rule wins
   // ---------------------------------------------------------------
   always_comb begin
      w_if_en   = 1'b1;
      w_id_en   = 1'b1;
      w_exe_en  = 1'b1;
      w_mem_en  = 1'b1;
      w_id_vld  = 1'b1;
      w_exe_vld = 1'b1;
      w_mem_vld = 1'b1;
      w_flush   = 1'b0;
      if (rst || (r_state == ST_ERROR)) begin
         w_if_en   = 1'b0;
         w_id_en   = 1'b0;
         w_exe_en  = 1'b0;
         w_mem_en  = 1'b0;
         w_id_vld  = 1'b0;
         w_exe_vld = 1'b0;
         w_mem_vld = 1'b0;
      end else if (w_mem_stall) begin
         w_if_en   = 1'b0;
         w_id_en   = 1'b0;
         w_exe_en  = 1'b0;
         w_mem_en  = 1'b0;
      end else if (w_md_hold) begin
         // Keep MEM moving, filling it with bubbles behind the older op.
         w_if_en   = 1'b0;
         w_id_en   = 1'b0;
         w_exe_en  = 1'b0;
         w_mem_vld = 1'b0;
      end else if (hc.EXE_redirect) begin
         // Wrong-path instructions in IF and ID are dropped; the dependent load
         // (if any) is on the wrong path too, so the hazard is moot.
         w_id_vld  = 1'b0;
         w_exe_vld = 1'b0;
         w_flush   = 1'b1;
      end else if (w_hazard) begin
         w_if_en   = 1'b0;
         w_id_en   = 1'b0;
         w_exe_vld = 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_wcnt      <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         if (!w_if_en && (r_state != ST_ERROR) && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush && (r_flush_cnt != CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign hc.IFreg_enable        = w_if_en;
   assign hc.IDreg_enable        = w_id_en;
   assign hc.EXEreg_enable       = w_exe_en;
   assign hc.MEMreg_enable       = w_mem_en;
   assign hc.IDreg_valid_fromCD  = w_id_vld;
   assign hc.EXEreg_valid_fromCD = w_exe_vld;
   assign hc.MEMreg_valid_fromCD = w_mem_vld;
   assign hc.mem_timeout         = (r_state == ST_ERROR);
   assign hc.stall_cnt           = r_stall_cnt;
   assign hc.flush_cnt           = r_flush_cnt;

endmodule

// File: tb/tb_ysyx_041461_hazard_ctrl.sv
// Purpose: directed bench for ysyx_041461_hazard_ctrl with a queue-based scoreboard.
// Latency: each vector is applied after a rising edge and checked at the following falling edge.
// Backpressure: n/a; the monitor consumes one expectation per cycle.
module tb_ysyx_041461_hazard_ctrl;

   localparam int CNT_W = 4;

   // Control word order: {IF_en, ID_en, EXE_en, MEM_en, ID_vld, EXE_vld, MEM_vld}
   localparam logic [6:0] R1 = 7'b0000_000; // reset / error
   localparam logic [6:0] R2 = 7'b0000_111; // memory stall
   localparam logic [6:0] R3 = 7'b0001_110; // mul/div hold
   localparam logic [6:0] R4 = 7'b1111_001; // redirect
   localparam logic [6:0] R5 = 7'b0011_101; // load-use
   localparam logic [6:0] R6 = 7'b1111_111; // free flow

   typedef struct {
      logic [6:0] ctl;
      int         to;
      int         st;
      int         fl;
      string      nm;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t e_mon;
   logic [6:0] act_ctl;

   ysyx_041461_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   ysyx_041461_hazard_ctrl #(
      .MEM_TIMEOUT (8),
      .CNT_W       (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hc  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // Monitor: pops one expectation per cycle and compares it with the DUT.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e_mon   = sb.pop_front();
         act_ctl = {bus.IFreg_enable, bus.IDreg_enable, bus.EXEreg_enable, bus.MEMreg_enable,
                    bus.IDreg_valid_fromCD, bus.EXEreg_valid_fromCD, bus.MEMreg_valid_fromCD};
         checks++;
         if (act_ctl !== e_mon.ctl) begin
            errors++;
            $display("FAIL %s ctl actual=%b required=%b", e_mon.nm, act_ctl, e_mon.ctl);
         end
         if (e_mon.to >= 0) begin
            checks++;
            if (bus.mem_timeout !== (e_mon.to != 0)) begin
               errors++;
               $display("FAIL %s mem_timeout actual=%b required=%0d", e_mon.nm, bus.mem_timeout, e_mon.to);
            end
         end
         if (e_mon.st >= 0) begin
            checks++;
            if (bus.stall_cnt !== CNT_W'(e_mon.st)) begin
               errors++;
               $display("FAIL %s stall_cnt actual=%0d required=%0d", e_mon.nm, bus.stall_cnt, e_mon.st);
            end
         end
         if (e_mon.fl >= 0) begin
            checks++;
            if (bus.flush_cnt !== CNT_W'(e_mon.fl)) begin
               errors++;
               $display("FAIL %s flush_cnt actual=%0d required=%0d", e_mon.nm, bus.flush_cnt, e_mon.fl);
            end
         end
      end
   end

   task automatic idle_in();
      bus.ID_valid      = 1'b0;
      bus.ID_rs1        = 5'd0;
      bus.ID_rs2        = 5'd0;
      bus.ID_rs1_used   = 1'b0;
      bus.ID_rs2_used   = 1'b0;
      bus.EXE_valid     = 1'b0;
      bus.EXE_rd        = 5'd0;
      bus.EXE_is_load   = 1'b0;
      bus.EXE_redirect  = 1'b0;
      bus.EXE_md_start  = 1'b0;
      bus.EXE_md_done   = 1'b0;
      bus.MEM_req_valid = 1'b0;
      bus.MEM_ready     = 1'b0;
      rst               = 1'b0;
   endtask

   // Queue the expectation for the inputs currently driven, then advance one cycle.
   task automatic chk(input logic [6:0] ctl, input int to, input int st, input int fl, input string nm);
      exp_t e;
      e.ctl = ctl;
      e.to  = to;
      e.st  = st;
      e.fl  = fl;
      e.nm  = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic load_use(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic ld);
      idle_in();
      bus.ID_valid    = 1'b1;
      bus.ID_rs1      = rs1;
      bus.ID_rs1_used = u1;
      bus.ID_rs2      = rs2;
      bus.ID_rs2_used = u2;
      bus.EXE_valid   = 1'b1;
      bus.EXE_rd      = rd;
      bus.EXE_is_load = ld;
   endtask

   task automatic mem_in(input logic rdy);
      idle_in();
      bus.MEM_req_valid = 1'b1;
      bus.MEM_ready     = rdy;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      idle_in();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset behaviour and reset state
      rst = 1'b1;  chk(R1, -1, -1, -1, "rst_first");
      rst = 1'b1;  chk(R1, 0, 0, 0, "rst_second");
      idle_in();   chk(R6, 0, 0, 0, "after_reset");

      // Load-use hazards
      load_use(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1); chk(R5, 0, 0, 0, "loaduse_rs1");
      load_use(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0); chk(R6, 0, 1, 0, "loaduse_release");
      load_use(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1); chk(R6, 0, 1, 0, "loaduse_rd0");
      load_use(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1); chk(R5, 0, 1, 0, "loaduse_rs2");
      load_use(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1); chk(R6, 0, 2, 0, "loaduse_rs2_unused");
      load_use(5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
      bus.ID_valid = 1'b0;                           chk(R6, 0, 2, 0, "loaduse_id_invalid");

      // Redirect beats a simultaneous hazard
      load_use(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
      bus.EXE_redirect = 1'b1;                       chk(R4, 0, 2, 0, "redirect_hazard");
      idle_in();                                     chk(R6, 0, 2, 1, "after_redirect");

      // Mul/div hold of 34 cycles; stall counter saturates at 15
      for (int k = 0; k < 34; k++) begin
         idle_in();
         bus.EXE_valid    = 1'b1;
         bus.EXE_md_start = (k == 0);
         chk(R3, 0, (2 + k > 15) ? 15 : 2 + k, 1, "md_freeze");
      end
      idle_in(); bus.EXE_valid = 1'b1; bus.EXE_md_done = 1'b1; chk(R6, 0, 15, 1, "md_done");
      idle_in(); bus.EXE_valid = 1'b1;                         chk(R6, 0, 15, 1, "md_back_run");

      // Reset in the middle of a mul/div hold
      idle_in(); bus.EXE_valid = 1'b1; bus.EXE_md_start = 1'b1; chk(R3, 0, 15, 1, "md2_start");
      idle_in(); bus.EXE_valid = 1'b1;                         chk(R3, 0, 15, 1, "md2_busy");
      idle_in(); bus.EXE_valid = 1'b1; rst = 1'b1;             chk(R1, 0, 15, 1, "md2_rst");
      idle_in(); bus.EXE_valid = 1'b1;                         chk(R6, 0, 0, 0, "md2_after_rst");

      // Memory wait of 5 cycles
      for (int k = 0; k < 5; k++) begin
         mem_in(1'b0); chk(R2, 0, k, 0, "memwait");
      end
      mem_in(1'b1); chk(R6, 0, 5, 0, "memwait_ready");
      idle_in();    chk(R6, 0, 5, 0, "memwait_after");

      // Start and done together: no hold
      idle_in(); bus.EXE_valid = 1'b1; bus.EXE_md_start = 1'b1; bus.EXE_md_done = 1'b1;
      chk(R6, 0, 5, 0, "md_start_done");
      idle_in(); bus.EXE_valid = 1'b1; chk(R6, 0, 5, 0, "md_start_done_next");

      // Start during a memory stall is ignored
      mem_in(1'b0); bus.EXE_valid = 1'b1; bus.EXE_md_start = 1'b1; chk(R2, 0, 5, 0, "md_start_in_stall");
      mem_in(1'b1); bus.EXE_valid = 1'b1; chk(R6, 0, 6, 0, "md_start_in_stall_ready");
      idle_in();    bus.EXE_valid = 1'b1; chk(R6, 0, 6, 0, "md_start_in_stall_next");

      // Memory stall during mul/div hold keeps the hold
      idle_in(); bus.EXE_valid = 1'b1; bus.EXE_md_start = 1'b1; chk(R3, 0, 6, 0, "md3_start");
      mem_in(1'b0); bus.EXE_valid = 1'b1; chk(R2, 0, 7, 0, "md3_memstall");
      idle_in(); bus.EXE_valid = 1'b1;    chk(R3, 0, 8, 0, "md3_still_busy");
      idle_in(); bus.EXE_valid = 1'b1; bus.EXE_md_done = 1'b1; chk(R6, 0, 9, 0, "md3_done");
      idle_in();                          chk(R6, 0, 9, 0, "md3_after");

      // Timeout boundary: ready on cycle 8 avoids the error
      for (int k = 0; k < 7; k++) begin
         mem_in(1'b0); chk(R2, 0, (9 + k > 15) ? 15 : 9 + k, 0, "tmo_boundary_wait");
      end
      mem_in(1'b1); chk(R6, 0, 15, 0, "tmo_boundary_ready");
      idle_in();    chk(R6, 0, 15, 0, "tmo_boundary_after");
      idle_in(); rst = 1'b1; chk(R1, 0, 15, 0, "rst_before_tmo");
      idle_in();             chk(R6, 0, 0, 0, "after_rst_tmo");

      // Timeout: 8 stall cycles enter the error state
      for (int k = 0; k < 8; k++) begin
         mem_in(1'b0); chk(R2, 0, k, 0, "tmo_wait");
      end
      mem_in(1'b0); chk(R1, 1, 8, 0, "tmo_error");
      idle_in(); bus.MEM_ready = 1'b1;    chk(R1, 1, 8, 0, "tmo_absorbing");
      idle_in(); bus.EXE_redirect = 1'b1; chk(R1, 1, 8, 0, "tmo_redirect_ignored");
      idle_in();                          chk(R1, 1, 8, 0, "tmo_no_flush");
      idle_in(); rst = 1'b1;              chk(R1, 1, 8, 0, "tmo_rst_cycle");
      idle_in();                          chk(R6, 0, 0, 0, "tmo_cleared");

      // Plain redirect
      idle_in(); bus.EXE_redirect = 1'b1; chk(R4, 0, 0, 0, "redirect_plain");
      idle_in();                          chk(R6, 0, 0, 1, "redirect_plain_after");

      for (int i = 0; i < 10 && sb.size() > 0; i++) begin
         @(negedge clk);
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_041461_hazard_ctrl.md
# ysyx_041461_hazard_ctrl

Pipeline hazard and stall controller. It drives the enable and bubble-insert (`valid_fromCD`) inputs of the IF/ID, ID/EXE and EXE/MEM pipeline registers. It resolves four conditions:
- load-use hazards
- control redirects from EXE
- multi-cycle mul/div occupancy of EXE
- memory wait states

A memory-wait watchdog and saturating performance counters are included. The block sits beside the pipeline registers and is their only source of `*_enable` / `*_valid_fromCD`.

## Interface
Parameters:
- `MEM_TIMEOUT`, 1024: maximum consecutive memory-wait cycles before the fatal ERROR state.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset. Synchronous, active-high.
- `ID_valid`  in  1  ID stage holds a valid instruction.
- `ID_rs1`, `ID_rs2`  in  5 each  ID source register indices.
- `ID_rs1_used`, `ID_rs2_used`  in  1 each  the corresponding source is actually read.
- `EXE_valid`  in  1  EXE stage holds a valid instruction.
- `EXE_rd`  in  5  EXE destination register.
- `EXE_is_load`  in  1  EXE instruction is a load.
- `EXE_redirect`  in  1  EXE resolved a taken jump/branch; PC redirect this cycle.
- `EXE_md_start`  in  1  pulse: mul/div unit accepted the EXE op this cycle.
- `EXE_md_done`  in  1  pulse: mul/div result valid this cycle.
- `MEM_req_valid`  in  1  MEM stage has an outstanding data access.
- `MEM_ready`  in  1  data access completes this cycle.
- `IFreg_enable`, `IDreg_enable`, `EXEreg_enable`, `MEMreg_enable`  out  1 each  pipeline register update enables.
- `IDreg_valid_fromCD`, `EXEreg_valid_fromCD`, `MEMreg_valid_fromCD`  out  1 each  0 inserts a bubble into that register.
- `mem_timeout`  out  1  sticky fatal error.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  performance counters.

## Operation
Internal signals:
- `mem_stall` = `MEM_req_valid & !MEM_ready`
- `hazard` = all of the following:
  - `ID_valid & EXE_valid & EXE_is_load & EXE_rd != 0`
  - `(ID_rs1_used & ID_rs1 == EXE_rd) | (ID_rs2_used & ID_rs2 == EXE_rd)`
- `md_hold` = `(state == MD_BUSY | (state == RUN & EXE_valid & EXE_md_start & !mem_stall)) & !EXE_md_done`

State register: RUN=0, MD_BUSY=1, MEM_WAIT=2, ERROR=3. Wait counter `wcnt` is `clog2(MEM_TIMEOUT)+1` bits.

Transitions:
- RUN:
  - `mem_stall` -> MEM_WAIT, `wcnt` = 1.
  - Else `md_hold` -> MD_BUSY.
  - Else stay in RUN.
- MEM_WAIT:
  - `MEM_ready` -> RUN, `wcnt` = 0.
  - Else if `wcnt == MEM_TIMEOUT-1` -> ERROR.
  - Else `wcnt`++.
- MD_BUSY:
  - `EXE_md_done` -> RUN.
  - A `mem_stall` from an older op in MEM does not change state; it only freezes MEM.
- ERROR: absorbing until `rst`.

Outputs are combinational. The first matching rule applies:
1. `rst` or ERROR: all enables = 0, all `valid_fromCD` = 0.
2. `mem_stall`: IF/ID/EXE/MEM enables = 0, all `valid_fromCD` = 1.
3. `md_hold`:
   - IF/ID/EXE enables = 0.
   - `MEMreg_enable` = 1, `MEMreg_valid_fromCD` = 0 (drain MEM with bubbles).
   - ID/EXE `valid_fromCD` = 1.
4. `EXE_redirect`:
   - All enables = 1.
   - `IDreg_valid_fromCD` = 0, `EXEreg_valid_fromCD` = 0 (kill the two wrong-path instructions).
   - `MEMreg_valid_fromCD` = 1.
   - Redirect takes priority over `hazard`.
5. `hazard`:
   - `IFreg_enable` = 0, `IDreg_enable` = 0.
   - `EXEreg_enable` = 1, `EXEreg_valid_fromCD` = 0.
   - MEM enable and valid = 1.
6. Otherwise: all enables = 1, all `valid_fromCD` = 1.

Rules:
- `EXE_md_start` is ignored while `mem_stall` = 1. The mul/div unit must not accept an op in that cycle.
- `mem_timeout` = (state == ERROR).

Counters:
- `stall_cnt`++ on every cycle with `IFreg_enable` = 0 and state != ERROR.
- `flush_cnt`++ on every cycle where rule 4 applies.
- Both saturate at all-ones and never wrap.

## Timing
- Reset is synchronous. After the `rst` cycle:
  - State is RUN; `wcnt`, `stall_cnt`, `flush_cnt` are 0; `mem_timeout` is 0.
  - During the `rst` cycle, outputs follow rule 1.
- `rst` asserted mid-MD_BUSY or mid-MEM_WAIT returns the block to RUN on the next edge. Counters clear.
- Load-use costs exactly 1 bubble cycle. The next cycle the load is in MEM and `hazard` drops.
- Redirect costs 2 killed slots. Outputs respond in the same cycle as `EXE_redirect`.
- MD_BUSY of N cycles from `EXE_md_start` to `EXE_md_done`:
  - IF/ID/EXE are frozen for N cycles.
  - They advance on the `EXE_md_done` cycle itself.
  - `md_start` and `md_done` in the same cycle: no freeze, no MD_BUSY entry.
- Timeout: ERROR is entered on the edge ending the `MEM_TIMEOUT`-th consecutive `mem_stall` cycle.
  - `MEM_ready` in that same cycle wins and the state returns to RUN.

## Test plan
- Load-use: `EXE` is a load with rd=5; `ID` has `rs1_used`=1, rs1=5 -> 1 cycle of `IF`/`IDreg_enable`=0 and `EXEreg_valid_fromCD`=0, then all 1; `stall_cnt` = 1. Repeat with rd=0 -> no stall.
- Redirect together with hazard: `EXE_redirect`=1 and `hazard`=1 in the same cycle -> all enables 1, ID/EXE `valid_fromCD`=0, `flush_cnt`=1.
- Mul/div: `md_start` at cycle 10, `md_done` at cycle 44 -> IF/ID/EXE enables 0 for cycles 10–43, `MEMreg_valid_fromCD`=0, enables 1 at cycle 44, state RUN at cycle 45.
- Memory wait: `MEM_req_valid`=1, `MEM_ready`=0 for 5 cycles, then 1 -> all 4 enables 0 for 5 cycles; state MEM_WAIT then RUN; `stall_cnt`=5.
- Timeout with `MEM_TIMEOUT`=8: `MEM_ready` held 0 -> `mem_timeout`=1 after the 8th cycle, all outputs 0; `rst` clears it; boundary variant with `MEM_ready`=1 on cycle 8 -> no error.
- Reset mid-MD_BUSY and counter saturation with `CNT_W`=4: 20 stall cycles -> `stall_cnt`=15.
